// File: rtl/score_bank.sv
// Per-player score/lives register bank with saturating points, bonus lives, sticky game-over
// and a retained high score, driven by a valid/ready command port with one response per command.
module score_bank #(
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned LIVES_W     = 3,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PLAYER_W    = 2,
  parameter int unsigned INIT_LIVES  = 3,
  parameter int unsigned MAX_LIVES   = 5,
  parameter int unsigned BONUS_STEP  = 1000
) (
  input  logic                clock_50,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [PLAYER_W-1:0] cmd_player,
  input  logic [SCORE_W-1:0]  cmd_data,
  output logic                rsp_valid,
  output logic [SCORE_W-1:0]  rsp_data,
  output logic                rsp_err,
  output logic [SCORE_W-1:0]  high_score,
  output logic                game_over
);

  localparam logic [2:0] OpNop        = 3'd0;
  localparam logic [2:0] OpReadScore  = 3'd1;
  localparam logic [2:0] OpReadLives  = 3'd2;
  localparam logic [2:0] OpWriteScore = 3'd3;
  localparam logic [2:0] OpWriteLives = 3'd4;
  localparam logic [2:0] OpAddPoints  = 3'd5;
  localparam logic [2:0] OpLoseLife   = 3'd6;
  localparam logic [2:0] OpNewGame    = 3'd7;

  localparam logic [LIVES_W-1:0] MaxLives  = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] InitLives = LIVES_W'(INIT_LIVES);
  localparam logic [SCORE_W:0]   BonusStep = (SCORE_W+1)'(BONUS_STEP);

  typedef enum logic [0:0] {StIdle, StAddChk} state_e;

  state_e                 state_q, state_d;
  logic [SCORE_W-1:0]     score_q      [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d      [NUM_PLAYERS];
  logic [LIVES_W-1:0]     lives_q      [NUM_PLAYERS];
  logic [LIVES_W-1:0]     lives_d      [NUM_PLAYERS];
  logic [SCORE_W:0]       next_bonus_q [NUM_PLAYERS];
  logic [SCORE_W:0]       next_bonus_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] chk_sel_q, chk_sel_d;
  logic                   game_over_q, game_over_d;
  logic [SCORE_W-1:0]     high_score_q, high_score_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [SCORE_W-1:0]     rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   accept, player_ok, start_add, lives_chk, all_zero;
  logic [NUM_PLAYERS-1:0] sel;
  logic [SCORE_W-1:0]     cur_score, sat_sum;
  logic [LIVES_W-1:0]     cur_lives, wr_lives, dec_lives;
  logic [SCORE_W:0]       sum;

  // Decode target channel; an out-of-range player leaves sel all-zero.
  always_comb begin
    sel       = '0;
    cur_score = '0;
    cur_lives = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (PLAYER_W'(i) == cmd_player) begin
        sel[i]    = 1'b1;
        cur_score = score_q[i];
        cur_lives = lives_q[i];
      end
    end
  end

  assign player_ok = |sel;
  assign accept    = cmd_valid && cmd_ready;
  assign start_add = accept && (cmd_op == OpAddPoints) && player_ok && !game_over_q;
  assign sum       = {1'b0, cur_score} + {1'b0, cmd_data};
  assign sat_sum   = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  assign wr_lives  = (cmd_data > SCORE_W'(MAX_LIVES)) ? MaxLives : cmd_data[LIVES_W-1:0];
  assign dec_lives = (cur_lives == '0) ? '0 : cur_lives - 1'b1;

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      chk_sel_q    <= '0;
      game_over_q  <= 1'b0;
      high_score_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i]      <= '0;
        lives_q[i]      <= InitLives;
        next_bonus_q[i] <= BonusStep;
      end
    end else begin
      state_q      <= state_d;
      chk_sel_q    <= chk_sel_d;
      game_over_q  <= game_over_d;
      high_score_q <= high_score_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      next_bonus_q <= next_bonus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_add) state_d = StAddChk;
      StAddChk: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    rsp_valid  = rsp_valid_q;
    rsp_data   = rsp_data_q;
    rsp_err    = rsp_err_q;
    high_score = high_score_q;
    game_over  = game_over_q;
  end

  always_comb begin
    score_d      = score_q;
    lives_d      = lives_q;
    next_bonus_d = next_bonus_q;
    chk_sel_d    = chk_sel_q;
    game_over_d  = game_over_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    lives_chk    = 1'b0;
    all_zero     = 1'b1;

    high_score_d = high_score_q;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > high_score_d) high_score_d = score_q[i];
    end

    if (state_q == StAddChk) begin
      // Score was already saturated on the accept edge; at most one bonus per ADD here.
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (chk_sel_q[i]) begin
          if ({1'b0, score_q[i]} >= next_bonus_q[i]) begin
            lives_d[i]      = (lives_q[i] < MaxLives) ? lives_q[i] + 1'b1 : MaxLives;
            next_bonus_d[i] = next_bonus_q[i] + BonusStep;
          end
          rsp_data_d = score_q[i];
        end
      end
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = '0;
      if (cmd_op == OpNewGame) begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
          score_d[i]      = '0;
          lives_d[i]      = InitLives;
          next_bonus_d[i] = BonusStep;
        end
        game_over_d = 1'b0;
      end else if (cmd_op == OpNop) begin
        rsp_data_d = '0;
      end else if (!player_ok) begin
        rsp_err_d = 1'b1;
      end else begin
        case (cmd_op)
          OpReadScore: rsp_data_d = cur_score;
          OpReadLives: rsp_data_d = SCORE_W'(cur_lives);
          OpWriteScore: begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) if (sel[i]) score_d[i] = cmd_data;
            rsp_data_d = cmd_data;
          end
          OpWriteLives: begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) if (sel[i]) lives_d[i] = wr_lives;
            rsp_data_d = SCORE_W'(wr_lives);
            lives_chk  = 1'b1;
          end
          OpAddPoints: begin
            if (game_over_q) begin
              rsp_data_d = cur_score;
            end else begin
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) if (sel[i]) score_d[i] = sat_sum;
              chk_sel_d   = sel;
              rsp_valid_d = 1'b0;
            end
          end
          OpLoseLife: begin
            if (game_over_q) begin
              rsp_data_d = SCORE_W'(cur_lives);
            end else begin
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) if (sel[i]) lives_d[i] = dec_lives;
              rsp_data_d = SCORE_W'(dec_lives);
              lives_chk  = 1'b1;
            end
          end
          default: rsp_data_d = '0;
        endcase
      end
    end

    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (lives_d[i] != '0) all_zero = 1'b0;
    end
    if (lives_chk && all_zero) game_over_d = 1'b1;
  end

endmodule

// File: tb/tb_score_bank.sv
// Randomised self-checking bench for score_bank against an arithmetic model of the game rules.
module tb_score_bank;

  localparam int NP = 2;
  localparam int OP_NOP = 0, OP_RS = 1, OP_RL = 2, OP_WS = 3, OP_WL = 4, OP_ADD = 5,
                 OP_LOSE = 6, OP_NEW = 7;

  logic        clock_50 = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_player;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] high_score;
  logic        game_over;

  int checks = 0;
  int failures = 0;

  int m_score [NP];
  int m_lives [NP];
  int m_nb    [NP];
  bit m_go;
  int m_hs;

  score_bank dut (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_player(cmd_player),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .high_score(high_score),
    .game_over (game_over)
  );

  always #10 clock_50 = ~clock_50;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_score[i] = 0;
      m_lives[i] = 3;
      m_nb[i]    = 1000;
    end
    m_go = 0;
  endtask

  function automatic bit all_dead();
    for (int i = 0; i < NP; i++) if (m_lives[i] != 0) return 0;
    return 1;
  endfunction

  // Apply one command to the model; returns expected response and latency in cycles.
  task automatic model_apply(input int op, input int p, input int d,
                             output int exp_data, output int exp_err, output int lat);
    exp_data = 0;
    exp_err  = 0;
    lat      = 1;
    if (op == OP_NEW) begin
      model_reset();
    end else if (op != OP_NOP) begin
      if (p >= NP) begin
        exp_err = 1;
      end else begin
        case (op)
          OP_RS: exp_data = m_score[p];
          OP_RL: exp_data = m_lives[p];
          OP_WS: begin m_score[p] = d; exp_data = d; end
          OP_WL: begin
            m_lives[p] = (d > 5) ? 5 : d;
            exp_data = m_lives[p];
            if (all_dead()) m_go = 1;
          end
          OP_ADD: begin
            if (m_go) exp_data = m_score[p];
            else begin
              m_score[p] = (m_score[p] + d > 65535) ? 65535 : m_score[p] + d;
              if (m_score[p] >= m_nb[p]) begin
                m_lives[p] = (m_lives[p] >= 5) ? 5 : m_lives[p] + 1;
                m_nb[p] += 1000;
              end
              exp_data = m_score[p];
              lat = 2;
            end
          end
          OP_LOSE: begin
            if (!m_go) begin
              if (m_lives[p] > 0) m_lives[p]--;
              if (all_dead()) m_go = 1;
            end
            exp_data = m_lives[p];
          end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < NP; i++) if (m_score[i] > m_hs) m_hs = m_score[i];
  endtask

  task automatic send(input int op, input int p, input int d);
    int exp_data, exp_err, lat;
    @(negedge clock_50);
    check_eq("ready_before", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_op     = 3'(op);
    cmd_player = 2'(p);
    cmd_data   = 16'(d);
    @(negedge clock_50);
    cmd_valid = 1'b0;
    model_apply(op, p, d, exp_data, exp_err, lat);
    if (lat == 2) begin
      check_eq("chk_ready_low", int'(cmd_ready), 0);
      check_eq("chk_no_rsp", int'(rsp_valid), 0);
      @(negedge clock_50);
    end
    check_eq("rsp_valid", int'(rsp_valid), 1);
    check_eq("rsp_data", int'(rsp_data), exp_data);
    check_eq("rsp_err", int'(rsp_err), exp_err);
    check_eq("ready_after", int'(cmd_ready), 1);
    check_eq("game_over", int'(game_over), int'(m_go));
    @(negedge clock_50);
    check_eq("rsp_pulse_end", int'(rsp_valid), 0);
    check_eq("rsp_data_hold", int'(rsp_data), exp_data);
    check_eq("high_score", int'(high_score), m_hs);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready", int'(cmd_ready), 1);
    check_eq("rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("rst_rsp_data", int'(rsp_data), 0);
    check_eq("rst_rsp_err", int'(rsp_err), 0);
    check_eq("rst_high_score", int'(high_score), 0);
    check_eq("rst_game_over", int'(game_over), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_player = '0;
    cmd_data   = '0;
    model_reset();
    m_hs = 0;
    repeat (3) @(negedge clock_50);
    reset_n = 1'b1;
    check_reset_outputs();

    send(OP_RL, 0, 0);
    send(OP_RS, 1, 0);

    send(OP_ADD, 0, 999);
    send(OP_RL, 0, 0);
    send(OP_ADD, 0, 1);
    send(OP_RL, 0, 0);
    check_eq("lives_bonus_p0", m_lives[0], 4);

    send(OP_WS, 1, 65530);
    send(OP_ADD, 1, 100);
    send(OP_RL, 1, 0);
    send(OP_ADD, 1, 5000);
    send(OP_RS, 1, 0);

    send(OP_WL, 0, 7);

    while (m_lives[0] > 0) send(OP_LOSE, 0, 0);
    while (m_lives[1] > 0) send(OP_LOSE, 1, 0);
    send(OP_LOSE, 1, 0);
    send(OP_ADD, 0, 50);
    send(OP_NEW, 0, 0);
    send(OP_RL, 1, 0);
    send(OP_RS, 0, 0);

    send(OP_RS, 3, 0);
    send(OP_WS, 3, 1234);
    send(OP_LOSE, 2, 0);
    send(OP_RS, 0, 0);
    send(OP_NOP, 1, 77);

    // Reset asserted while the ADD is in its check cycle.
    @(negedge clock_50);
    cmd_valid  = 1'b1;
    cmd_op     = 3'(OP_ADD);
    cmd_player = 2'd0;
    cmd_data   = 16'd1500;
    @(negedge clock_50);
    cmd_valid = 1'b0;
    check_eq("abort_in_chk", int'(cmd_ready), 0);
    reset_n = 1'b0;
    @(negedge clock_50);
    reset_n = 1'b1;
    check_reset_outputs();
    @(negedge clock_50);
    check_eq("abort_no_rsp", int'(rsp_valid), 0);
    model_reset();
    m_hs = 0;
    send(OP_RS, 0, 0);
    send(OP_RL, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int op, p, d;
      op = int'($urandom_range(0, 7));
      p  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      case (op)
        OP_ADD:  d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                                 : int'($urandom_range(0, 3000));
        OP_WS:   d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(65000, 65535))
                                                 : int'($urandom_range(0, 65535));
        OP_WL:   d = int'($urandom_range(0, 9));
        default: d = int'($urandom_range(0, 65535));
      endcase
      send(op, p, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
